// File: rtl/fifo_to_mem_writer.sv
// fifo_to_mem_writer: drains a standard-read FIFO into a word-addressed
// memory write port over an inclusive address range, optionally wrapping.
// A one-entry skid register absorbs the word returning from the FIFO
// while the memory applies back-pressure.
// Optional build macro: FIFO_TO_MEM_WRITER_STATS_EN enables the
// wr_count / stall_count statistics; without it both read as 0.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; no FIFO reads, no memory writes
//   RUN   | reading FIFO and writing memory from addr_low upward
//   DONE  | range finished (wrap_en=0); returns to IDLE once start is low
module fifo_to_mem_writer #(
    parameter int FIFO_DATA_WIDTH = 72,
    parameter int MEM_ADDR_WIDTH  = 19
) (
    input  logic                       fifo_clk,
    input  logic                       rst,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_dout,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    input  logic                       start,
    input  logic                       wrap_en,
    input  logic [MEM_ADDR_WIDTH-1:0]  addr_low,
    input  logic [MEM_ADDR_WIDTH-1:0]  addr_high,
    output logic                       mem_wr_en,
    output logic [MEM_ADDR_WIDTH-1:0]  mem_wr_addr,
    output logic [FIFO_DATA_WIDTH-1:0] mem_wr_data,
    input  logic                       mem_wr_full,
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                wr_count,
    output logic [31:0]                stall_count
);

    // One extra bit so a range spanning the whole address space counts
    // 2^MEM_ADDR_WIDTH words instead of collapsing to zero.
    localparam int RW = MEM_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state;
    logic [MEM_ADDR_WIDTH-1:0]  ptr;
    logic [RW-1:0]              remaining;
    logic                       in_flight;
    logic                       skid_vld;
    logic [FIFO_DATA_WIDTH-1:0] skid_data;

    logic                       running;
    logic                       have_word;
    logic                       wr_fire;
    logic                       rd_fire;
    logic                       skid_busy_next;
    logic                       at_high;
    logic [RW-1:0]              outstanding;
    logic [MEM_ADDR_WIDTH-1:0]  span;

    assign running   = (state == RUN);
    assign have_word = skid_vld | in_flight;
    assign wr_fire   = running & have_word & ~mem_wr_full;

    // Skid stays/becomes occupied if a word is held back by the memory, or
    // if the skid drains while a fresh FIFO word lands at the same time.
    assign skid_busy_next = mem_wr_full ? have_word : (skid_vld & in_flight);

    // Words already read but not yet written must not exceed what is left.
    assign outstanding = RW'(in_flight) + RW'(skid_vld);
    assign rd_fire     = running & ~fifo_empty & ~skid_busy_next &
                         (wrap_en | (remaining > outstanding));

    assign at_high = (ptr == addr_high);
    assign span    = addr_high - addr_low;

    assign fifo_rd_en  = rd_fire;
    assign mem_wr_en   = wr_fire;
    assign mem_wr_addr = ptr;
    assign mem_wr_data = wr_fire ? (skid_vld ? skid_data : fifo_dout) : '0;
    assign busy        = running;
    assign done        = (state == DONE);

    // Sequencer: state, address pointer, word budget and skid bookkeeping.
    always_ff @(posedge fifo_clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            in_flight <= 1'b0;
            skid_vld  <= 1'b0;
            skid_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_flight <= 1'b0;
                    skid_vld  <= 1'b0;
                    if (start) begin
                        state     <= RUN;
                        ptr       <= addr_low;
                        remaining <= {1'b0, span} + RW'(1);
                    end
                end
                RUN: begin
                    in_flight <= rd_fire;
                    skid_vld  <= skid_busy_next;
                    if (in_flight && (mem_wr_full || skid_vld))
                        skid_data <= fifo_dout;
                    if (wr_fire) begin
                        ptr <= at_high ? addr_low : ptr + MEM_ADDR_WIDTH'(1);
                        if (remaining != '0)
                            remaining <= remaining - RW'(1);
                        if (at_high && !wrap_en)
                            state <= DONE;
                    end
                end
                DONE: begin
                    in_flight <= 1'b0;
                    skid_vld  <= 1'b0;
                    if (!start)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_TO_MEM_WRITER_STATS_EN
    logic [31:0] wr_cnt_q;
    logic [31:0] stall_cnt_q;

    // Saturating write and back-pressure counters, cleared on each start.
    always_ff @(posedge fifo_clk) begin
        if (rst) begin
            wr_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else if (state == IDLE && start) begin
            wr_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (wr_fire && wr_cnt_q != '1)
                wr_cnt_q <= wr_cnt_q + 32'd1;
            if (running && have_word && mem_wr_full && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign wr_count    = wr_cnt_q;
    assign stall_count = stall_cnt_q;
`else
    assign wr_count    = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fifo_to_mem_writer.sv
// Directed bench for fifo_to_mem_writer: a table of single-pass range runs
// plus hand sequences for wrap, memory back-pressure and mid-run reset.
module tb_fifo_to_mem_writer;

    localparam int DW = 72;
    localparam int AW = 19;

    logic          fifo_clk = 1'b0;
    logic          rst, start, wrap_en, mem_wr_full;
    logic [AW-1:0] addr_low, addr_high;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_empty, fifo_rd_en, mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          busy, done;
    logic [31:0]   wr_count, stall_count;

    always #5 fifo_clk = ~fifo_clk;

    fifo_to_mem_writer #(.FIFO_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW)) dut (
        .fifo_clk   (fifo_clk),
        .rst        (rst),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .start      (start),
        .wrap_en    (wrap_en),
        .addr_low   (addr_low),
        .addr_high  (addr_high),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .mem_wr_full(mem_wr_full),
        .busy       (busy),
        .done       (done),
        .wr_count   (wr_count),
        .stall_count(stall_count)
    );

    // Standard-read FIFO model and memory write log.
    logic [DW-1:0] fifo_mem [0:127];
    int            wr_idx = 0;
    int            rd_idx = 0;
    int            rd_pulses = 0;
    int            underflows = 0;
    logic [AW-1:0] log_addr [0:255];
    logic [DW-1:0] log_data [0:255];
    int            log_n = 0;

    assign fifo_empty = (rd_idx == wr_idx);

    always @(posedge fifo_clk) begin
        if (fifo_rd_en) begin
            if (rd_idx != wr_idx) begin
                fifo_dout <= fifo_mem[rd_idx];
                rd_idx    <= rd_idx + 1;
                rd_pulses <= rd_pulses + 1;
            end else begin
                underflows <= underflows + 1;
            end
        end
        if (mem_wr_en && log_n < 256) begin
            log_addr[log_n] <= mem_wr_addr;
            log_data[log_n] <= mem_wr_data;
            log_n           <= log_n + 1;
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input int k);
        return {8'hFF, 32'hC0DE_0000 + 32'(k), 32'(k) * 32'd7 + 32'd1};
    endfunction

    task automatic push_words(input int n);
        for (int k = 0; k < n; k++) begin
            fifo_mem[wr_idx] = word_of(wr_idx);
            wr_idx++;
        end
    endtask

    task automatic pulse_start();
        @(negedge fifo_clk);
        start = 1'b1;
        @(negedge fifo_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output logic got);
        got = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge fifo_clk);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " fifo_rd_en"}, 128'(fifo_rd_en), 128'(0));
        check({tag, " mem_wr_en"}, 128'(mem_wr_en), 128'(0));
        check({tag, " mem_wr_addr"}, 128'(mem_wr_addr), 128'(0));
        check({tag, " mem_wr_data"}, 128'(mem_wr_data), 128'(0));
        check({tag, " busy"}, 128'(busy), 128'(0));
        check({tag, " done"}, 128'(done), 128'(0));
        check({tag, " wr_count"}, 128'(wr_count), 128'(0));
        check({tag, " stall_count"}, 128'(stall_count), 128'(0));
    endtask

    typedef struct {
        logic [AW-1:0] lo;
        logic [AW-1:0] hi;
        int            push;
        int            exp_writes;
        int            exp_left;
        logic [AW-1:0] exp_last;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int            base_log, base_rd, base_pulses, snap, nw;
        logic          got;
        logic [AW-1:0] ea;
        logic [AW-1:0] wrap_exp [7];

        // FIFO leftovers carry from one vector into the next.
        vecs[0] = '{lo: 19'h00010, hi: 19'h00013, push: 6, exp_writes: 4, exp_left: 2, exp_last: 19'h00013};
        vecs[1] = '{lo: 19'h7FFFF, hi: 19'h7FFFF, push: 0, exp_writes: 1, exp_left: 1, exp_last: 19'h7FFFF};
        vecs[2] = '{lo: 19'h7FFFE, hi: 19'h00001, push: 3, exp_writes: 4, exp_left: 0, exp_last: 19'h00001};
        vecs[3] = '{lo: 19'h00100, hi: 19'h00107, push: 8, exp_writes: 8, exp_left: 0, exp_last: 19'h00107};
        vecs[4] = '{lo: 19'h00005, hi: 19'h00005, push: 2, exp_writes: 1, exp_left: 1, exp_last: 19'h00005};
        wrap_exp = '{19'd0, 19'd1, 19'd2, 19'd0, 19'd1, 19'd2, 19'd0};

        rst = 1'b1; start = 1'b0; wrap_en = 1'b0; mem_wr_full = 1'b0;
        addr_low = '0; addr_high = '0;
        repeat (3) @(negedge fifo_clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge fifo_clk);

        for (int v = 0; v < 5; v++) begin
            wrap_en   = 1'b0;
            addr_low  = vecs[v].lo;
            addr_high = vecs[v].hi;
            push_words(vecs[v].push);
            base_log = log_n; base_rd = rd_idx; base_pulses = rd_pulses;
            pulse_start();
            wait_done(got);
            check($sformatf("v%0d done", v), 128'(got), 128'(1));
            check($sformatf("v%0d busy_in_done", v), 128'(busy), 128'(0));
            @(negedge fifo_clk);
            check($sformatf("v%0d back_to_idle", v), 128'({busy, done}), 128'(0));
            repeat (3) @(negedge fifo_clk);
            nw = log_n - base_log;
            check($sformatf("v%0d writes", v), 128'(nw), 128'(vecs[v].exp_writes));
            check($sformatf("v%0d reads", v), 128'(rd_pulses - base_pulses), 128'(vecs[v].exp_writes));
            check($sformatf("v%0d fifo_left", v), 128'(wr_idx - rd_idx), 128'(vecs[v].exp_left));
            for (int i = 0; i < nw && i < vecs[v].exp_writes; i++) begin
                ea = vecs[v].lo + AW'(i);
                check($sformatf("v%0d addr%0d", v, i), 128'(log_addr[base_log + i]), 128'(ea));
                check($sformatf("v%0d data%0d", v, i), 128'(log_data[base_log + i]), 128'(word_of(base_rd + i)));
            end
            if (nw > 0)
                check($sformatf("v%0d last_addr", v), 128'(log_addr[log_n - 1]), 128'(vecs[v].exp_last));
        end

        // Wrap over 0..2 with seven words available (one left from v4).
        wrap_en = 1'b1; addr_low = 19'd0; addr_high = 19'd2;
        push_words(6);
        base_log = log_n; base_rd = rd_idx;
        pulse_start();
        for (int c = 0; c < 100 && (log_n - base_log) < 7; c++) @(negedge fifo_clk);
        repeat (5) @(negedge fifo_clk);
        nw = log_n - base_log;
        check("wrap writes", 128'(nw), 128'(7));
        check("wrap busy", 128'(busy), 128'(1));
        check("wrap done", 128'(done), 128'(0));
        for (int i = 0; i < nw && i < 7; i++) begin
            check($sformatf("wrap addr%0d", i), 128'(log_addr[base_log + i]), 128'(wrap_exp[i]));
            check($sformatf("wrap data%0d", i), 128'(log_data[base_log + i]), 128'(word_of(base_rd + i)));
        end
        rst = 1'b1;
        @(negedge fifo_clk);
        check("wrap rst busy", 128'(busy), 128'(0));
        rst = 1'b0; wrap_en = 1'b0;
        @(negedge fifo_clk);

        // Memory back-pressure for five cycles during steady reads.
        addr_low = 19'h40; addr_high = 19'h4B;
        push_words(12);
        base_log = log_n; base_rd = rd_idx; base_pulses = rd_pulses;
        pulse_start();
        for (int c = 0; c < 50 && (log_n - base_log) < 4; c++) @(negedge fifo_clk);
        mem_wr_full = 1'b1;
        snap = log_n;
        repeat (5) @(negedge fifo_clk);
        check("stall no_writes", 128'(log_n - snap), 128'(0));
        mem_wr_full = 1'b0;
        wait_done(got);
        check("stall done", 128'(got), 128'(1));
`ifdef FIFO_TO_MEM_WRITER_STATS_EN
        check("stall stall_count", 128'(stall_count), 128'(5));
        check("stall wr_count", 128'(wr_count), 128'(12));
`else
        check("stall stall_count", 128'(stall_count), 128'(0));
        check("stall wr_count", 128'(wr_count), 128'(0));
`endif
        repeat (2) @(negedge fifo_clk);
        nw = log_n - base_log;
        check("stall writes", 128'(nw), 128'(12));
        check("stall reads", 128'(rd_pulses - base_pulses), 128'(12));
        for (int i = 0; i < nw && i < 12; i++) begin
            check($sformatf("stall addr%0d", i), 128'(log_addr[base_log + i]), 128'(19'h40 + 19'(i)));
            check($sformatf("stall data%0d", i), 128'(log_data[base_log + i]), 128'(word_of(base_rd + i)));
        end

        // Reset two cycles after start with words in flight; start held
        // high alongside reset must not relaunch the run.
        addr_low = 19'h200; addr_high = 19'h20F;
        push_words(8);
        pulse_start();
        @(negedge fifo_clk);
        rst = 1'b1; start = 1'b1;
        @(negedge fifo_clk);
        check_outputs_zero("midrun_rst");
        rst = 1'b0; start = 1'b0;
        snap = log_n;
        repeat (10) @(negedge fifo_clk);
        check("midrun no_writes", 128'(log_n - snap), 128'(0));
        check("midrun idle", 128'({busy, done}), 128'(0));
        check("fifo underflows", 128'(underflows), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
